// File: rtl/neuron_mac_sequencer.sv
// Sequential multiply-accumulate for one neuron: sum of w[i]*x[i] over
// N_INPUTS pairs. One shared multiplier and one shared adder are reused for every pair.
// Also holds the two single-precision arithmetic units that the sequencer shares.
// These units flush denormals to zero and round to nearest-even.

// IEEE-754 single multiplier, combinational.
module Fmultiplier (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out
);
    logic        w_sign;
    logic [23:0] w_ma, w_mb, w_m24;
    logic [47:0] w_prod;
    logic [24:0] w_rnd;
    logic        w_g, w_st;
    int          w_e;

    // Normalise the 48-bit product, round, then resolve special cases
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        w_sign = A[31] ^ B[31];
        w_ma   = (A[30:23] != 8'd0) ? {1'b1, A[22:0]} : 24'd0;
        w_mb   = (B[30:23] != 8'd0) ? {1'b1, B[22:0]} : 24'd0;
        w_prod = 48'(w_ma) * 48'(w_mb);
        w_e    = int'(A[30:23]) + int'(B[30:23]) - 127;
        if (w_prod[47]) begin
            w_m24 = w_prod[47:24];
            w_g   = w_prod[23];
            w_st  = |w_prod[22:0];
            w_e   = w_e + 1;
        end else begin
            w_m24 = w_prod[46:23];
            w_g   = w_prod[22];
            w_st  = |w_prod[21:0];
        end
        w_rnd = {1'b0, w_m24} + 25'(w_g & (w_st | w_m24[0]));
        if (w_rnd[24]) begin
            w_e   = w_e + 1;
            w_rnd = w_rnd >> 1;
        end
        if ((A[30:23] == 8'hFF && A[22:0] != 23'd0) || (B[30:23] == 8'hFF && B[22:0] != 23'd0) ||
            (A[30:23] == 8'hFF && w_mb == 24'd0) || (B[30:23] == 8'hFF && w_ma == 24'd0))
            Out = 32'h7FC00000;
        else if (A[30:23] == 8'hFF || B[30:23] == 8'hFF)
            Out = {w_sign, 8'hFF, 23'd0};
        else if (w_ma == 24'd0 || w_mb == 24'd0 || w_e <= 0)
            Out = {w_sign, 31'd0};
        else if (w_e >= 255)
            Out = {w_sign, 8'hFF, 23'd0};
        else
            Out = {w_sign, w_e[7:0], w_rnd[22:0]};
    end
endmodule

// IEEE-754 single adder/subtractor, combinational; IsSub negates B.
module Fadder_Fsubtractor (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        IsSub,
    output logic [31:0] Out
);
    logic [31:0] w_b, w_big, w_sml;
    logic [23:0] w_ml, w_ms;
    logic [7:0]  w_d;
    logic [26:0] w_al, w_lost, w_norm;
    logic [27:0] w_sum;
    logic [24:0] w_rnd;
    logic [4:0]  w_lz;
    logic        w_found, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    int          w_e;

    // Align the smaller operand, add or subtract magnitudes, renormalise and round
    always_comb begin
        w_b = {B[31] ^ IsSub, B[30:0]};
        if (A[30:0] >= w_b[30:0]) begin
            w_big = A;
            w_sml = w_b;
        end else begin
            w_big = w_b;
            w_sml = A;
        end
        w_ml = (w_big[30:23] != 8'd0) ? {1'b1, w_big[22:0]} : 24'd0;
        w_ms = (w_sml[30:23] != 8'd0) ? {1'b1, w_sml[22:0]} : 24'd0;
        w_d  = w_big[30:23] - w_sml[30:23];
        // Shifted-out bits collapse into a sticky bit at position 0
        if (w_d > 8'd26) begin
            w_al   = 27'd0;
            w_lost = {w_ms, 3'b000};
        end else begin
            w_al   = {w_ms, 3'b000} >> w_d;
            w_lost = {w_ms, 3'b000} & ~({27{1'b1}} << w_d);
        end
        w_al[0] = w_al[0] | (|w_lost);
        if (w_big[31] == w_sml[31])
            w_sum = {1'b0, w_ml, 3'b000} + {1'b0, w_al};
        else
            w_sum = {1'b0, w_ml, 3'b000} - {1'b0, w_al};
        w_e     = int'(w_big[30:23]);
        w_lz    = 5'd0;
        w_found = 1'b0;
        if (w_sum[27]) begin
            w_norm    = w_sum[27:1];
            w_norm[0] = w_norm[0] | w_sum[0];
            w_e       = w_e + 1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!w_found) begin
                    if (w_sum[i]) w_found = 1'b1;
                    else          w_lz = w_lz + 5'd1;
                end
            end
            w_norm = w_sum[26:0] << w_lz;
            w_e    = w_e - int'(w_lz);
        end
        w_rnd = {1'b0, w_norm[26:3]} + 25'(w_norm[2] & ((|w_norm[1:0]) | w_norm[3]));
        if (w_rnd[24]) begin
            w_e   = w_e + 1;
            w_rnd = w_rnd >> 1;
        end
        w_a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
        w_b_nan = (w_b[30:23] == 8'hFF) && (w_b[22:0] != 23'd0);
        w_a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
        w_b_inf = (w_b[30:23] == 8'hFF) && (w_b[22:0] == 23'd0);
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (A[31] != w_b[31])))
            Out = 32'h7FC00000;
        else if (w_a_inf)
            Out = A;
        else if (w_b_inf)
            Out = w_b;
        else if (w_sum == 28'd0)
            Out = 32'h00000000;
        else if (w_e >= 255)
            Out = {w_big[31], 8'hFF, 23'd0};
        else if (w_e <= 0)
            Out = {w_big[31], 31'd0};
        else
            Out = {w_big[31], w_e[7:0], w_rnd[22:0]};
    end
endmodule

// Sequencer: MUL/ACC alternate once per pair, then a single DONE cycle.
module neuron_mac_sequencer #(
    parameter int N_INPUTS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*N_INPUTS-1:0] x_flat,
    input  logic [32*N_INPUTS-1:0] w_flat,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           result
);
    localparam int                IDX_W    = $clog2(N_INPUTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t                        r_state, w_next_state;
    logic [N_INPUTS-1:0][31:0]     r_x, r_w;
    logic [IDX_W-1:0]              r_idx;
    logic [31:0]                   r_prod, r_acc, r_result;
    logic [31:0]                   w_prod, w_sum, w_acc_next;

    Fmultiplier u_mul (
        .A   (r_w[r_idx]),
        .B   (r_x[r_idx]),
        .Out (w_prod)
    );

    Fadder_Fsubtractor u_add (
        .A     (r_acc),
        .B     (r_prod),
        .IsSub (1'b0),
        .Out   (w_sum)
    );

    // First pair seeds the accumulator directly; later pairs go through the adder
    assign w_acc_next = (r_idx == '0) ? r_prod : w_sum;
    assign result     = r_result;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic and status outputs; start is only honoured in IDLE
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != IDLE);
        done         = (r_state == DONE);
        case (r_state)
            IDLE:    if (start) w_next_state = MUL;
            MUL:     w_next_state = ACC;
            ACC:     w_next_state = (r_idx == LAST_IDX) ? DONE : MUL;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, product/accumulator registers, result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand registers are reset too; they are few and this keeps the mux inputs defined.
            r_x      <= '0;
            r_w      <= '0;
            r_idx    <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x   <= x_flat;
                        r_w   <= w_flat;
                        r_idx <= '0;
                    end
                end
                MUL: r_prod <= w_prod;
                ACC: begin
                    r_acc <= w_acc_next;
                    // The final sum lands in result on the edge entering DONE so it is valid with done
                    if (r_idx == LAST_IDX) r_result <= w_acc_next;
                    else                   r_idx    <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer: N=3 and N=4 instances, expected sums hand-computed.
module tb_neuron_mac_sequencer;
    localparam logic [31:0] F_1   = 32'h3F800000;
    localparam logic [31:0] F_2   = 32'h40000000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_4   = 32'h40800000;
    localparam logic [31:0] F_10  = 32'h41200000;
    localparam logic [31:0] F_H   = 32'h3F000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start3, start4;
    logic [95:0]  x3, w3;
    logic [127:0] x4, w4;
    logic         busy3, done3, busy4, done4;
    logic [31:0]  result3, result4;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    neuron_mac_sequencer #(.N_INPUTS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .x_flat(x3), .w_flat(w3),
        .busy(busy3), .done(done3), .result(result3)
    );

    neuron_mac_sequencer #(.N_INPUTS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .x_flat(x4), .w_flat(w4),
        .busy(busy4), .done(done4), .result(result4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One N=3 operation; packing is {x2, x1, x0}. Pokes start while busy and in DONE.
    task automatic op3(input string tag, input logic [95:0] x, input logic [95:0] w,
                       input logic [31:0] exp);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start3 = 1'b1; x3 = x; w3 = w;
        @(posedge clk); #1;
        start3 = 1'b0; x3 = ~x; w3 = ~w;
        busy_cnt = busy3 ? 1 : 0;
        lat = 0;
        while (!done3 && lat < 20) begin
            start3 = (lat == 1 || lat == 2);
            @(posedge clk); #1;
            lat++;
            if (busy3) busy_cnt++;
        end
        start3 = 1'b1;
        check({tag, " latency"}, 32'(lat), 32'd6);
        check({tag, " result"}, result3, exp);
        @(posedge clk); #1;
        start3 = 1'b0;
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd7);
        check({tag, " done width"}, {31'd0, done3}, 32'd0);
        check({tag, " start in DONE ignored"}, {31'd0, busy3}, 32'd0);
        check({tag, " result held"}, result3, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd;
        int lat;
        logic [31:0] exp_s [3];
        rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
        x3 = '0; w3 = '0; x4 = '0; w4 = '0;
        #12;
        check("reset busy3", {31'd0, busy3}, 32'd0);
        check("reset done3", {31'd0, done3}, 32'd0);
        check("reset result3", result3, 32'd0);
        check("reset busy4", {31'd0, busy4}, 32'd0);
        check("reset result4", result4, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // start on the first edge after reset release
        op3("sum123", {F_3, F_2, F_1}, {F_1, F_1, F_1}, 32'h40C00000);
        op3("half", {F_2, F_2, F_2}, {F_H, F_H, F_H}, 32'h40400000);
        op3("signed", {F_2, F_1, F_3}, {32'hBF000000, 32'hBF800000, F_1}, 32'h3F800000);
        // 1.5*2 + 2.5*2 + (-4)*0.25 = 7
        op3("mixed", {32'hC0800000, 32'h40200000, 32'h3FC00000},
            {32'h3E800000, F_2, F_2}, 32'h40E00000);
        // -1 - 2 + 3 cancels to +0
        op3("cancel", {F_3, F_2, F_1}, {F_1, 32'hBF800000, 32'hBF800000}, 32'h00000000);
        op3("restore", {F_3, F_2, F_1}, {F_1, F_1, F_1}, 32'h40C00000);

        // start held high, operands change every cycle; accepted at edges 0, 8, 16
        exp_s[0] = F_3; exp_s[1] = 32'h40C00000; exp_s[2] = 32'h41400000;
        nd = 0;
        @(negedge clk);
        start3 = 1'b1; x3 = {3{F_1}}; w3 = {3{F_1}};
        for (int c = 0; c <= 23; c++) begin
            @(posedge clk); #1;
            if (c > 0 && done3) begin
                if (nd < 3) begin
                    check("stream edge", 32'(c), 32'(6 + 8 * nd));
                    check("stream result", result3, exp_s[nd]);
                end
                nd++;
            end
            x3 = (c + 1 == 8) ? {3{F_2}} : (c + 1 == 16) ? {3{F_4}} : {3{F_10}};
        end
        start3 = 1'b0;
        check("stream done count", 32'(nd), 32'd3);
        repeat (2) @(posedge clk);

        // reset in the cycle after E3 abandons the operation
        @(negedge clk);
        start3 = 1'b1; x3 = {3{F_1}}; w3 = {3{F_1}};
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", {31'd0, busy3}, 32'd0);
        check("midrst done", {31'd0, done3}, 32'd0);
        check("midrst result", result3, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done3) nd++;
        end
        check("midrst no done", 32'(nd), 32'd0);
        op3("after rst", {F_2, F_2, F_2}, {F_H, F_H, F_H}, 32'h40400000);

        // N=4 instance
        @(negedge clk);
        start4 = 1'b1; x4 = {4{F_1}}; w4 = {4{F_1}};
        @(posedge clk); #1;
        start4 = 1'b0; x4 = '0; w4 = '0;
        lat = 0;
        while (!done4 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n4 latency", 32'(lat), 32'd8);
        check("n4 result", result4, F_4);
        @(posedge clk); #1;
        check("n4 idle", {31'd0, busy4}, 32'd0);
        check("n3 untouched", {31'd0, busy3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
